// File: rtl/mixer_ctrl_pkg.sv
// Shared constants, register map and pan-sequencer state type for the
// mixer control/scheduling block.
package mixer_ctrl_pkg;

   localparam int GAIN_W = 20;
   localparam int VOL_W  = 25;
   localparam int PAN_W  = 16;

   localparam logic [GAIN_W-1:0] STEP_DEFAULT = 20'h00100;

   localparam logic [2:0] ADDR_VOL1   = 3'd0;
   localparam logic [2:0] ADDR_VOL2   = 3'd1;
   localparam logic [2:0] ADDR_VOL3   = 3'd2;
   localparam logic [2:0] ADDR_MASTER = 3'd3;
   localparam logic [2:0] ADDR_PAN    = 3'd4;
   localparam logic [2:0] ADDR_STEP   = 3'd5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      SWAP     = 2'd2,
      FADE_IN  = 2'd3
   } pan_state_t;

endpackage

// File: rtl/mixer_ctrl_vol_ramp.sv
// One volume ramp: moves cur toward its (possibly overridden) target by at
// most step per tick, clamping at the target so it never overshoots or wraps.
module vol_ramp
   import mixer_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [GAIN_W-1:0] step,
   input  logic [GAIN_W-1:0] tgt,
   input  logic              override_en,
   input  logic [GAIN_W-1:0] override_tgt,
   output logic [GAIN_W-1:0] cur,
   output logic              at_tgt
);

   logic [GAIN_W-1:0] eff_tgt;
   logic [GAIN_W-1:0] cur_next;
   logic [GAIN_W:0]   sum;
   logic [GAIN_W:0]   diff;

   assign eff_tgt = override_en ? override_tgt : tgt;
   assign at_tgt  = (cur == eff_tgt);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cur_next = cur;
      sum      = {1'b0, cur} + {1'b0, step};
      diff     = {1'b0, cur} - {1'b0, step};
      if (step == '0) begin
         cur_next = eff_tgt;
      end else if (cur < eff_tgt) begin
         cur_next = (sum > {1'b0, eff_tgt}) ? eff_tgt : sum[GAIN_W-1:0];
      end else if (cur > eff_tgt) begin
         // diff[GAIN_W] set means the subtraction went below zero.
         cur_next = (diff[GAIN_W] || (diff[GAIN_W-1:0] < eff_tgt)) ? eff_tgt : diff[GAIN_W-1:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= '0;
      end else if (tick) begin
         cur <= cur_next;
      end
   end

endmodule

// File: rtl/mixer_ctrl_sched.sv
// Host-facing register file, per-sample volume ramps and the click-free
// pan sequencer (fade master out, swap pan, fade master back in).
module mixer_ctrl_sched
   import mixer_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_tick,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [VOL_W-1:0] wr_data,
   output logic             wr_ready,
   output logic [VOL_W-1:0] volume1,
   output logic [VOL_W-1:0] volume2,
   output logic [VOL_W-1:0] volume3,
   output logic [VOL_W-1:0] volume_master,
   output logic [PAN_W-1:0] pan,
   output logic             busy,
   output logic             pan_done
);

   pan_state_t        state, state_next;
   logic [GAIN_W-1:0] tgt_q  [4];
   logic [GAIN_W-1:0] cur    [4];
   logic [3:0]        at_tgt;
   logic [GAIN_W-1:0] step_q;
   logic [PAN_W-1:0]  shadow_q;
   logic              accept;
   logic              fade_out;
   logic              pan_load;
   logic              done_set;
   logic              unused_wr_bits;

   assign wr_ready       = (state == IDLE);
   assign accept         = wr_en && wr_ready;
   assign fade_out       = (state == FADE_OUT);
   assign unused_wr_bits = ^wr_data[VOL_W-1:GAIN_W];

   // NOTE: the target array is reset explicitly because a reset must leave no stale target behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) tgt_q[i] <= '0;
         step_q   <= STEP_DEFAULT;
         shadow_q <= '0;
      end else if (accept) begin
         case (wr_addr)
            ADDR_VOL1, ADDR_VOL2, ADDR_VOL3, ADDR_MASTER:
               tgt_q[wr_addr[1:0]] <= wr_data[GAIN_W-1:0];
            ADDR_PAN:  shadow_q <= wr_data[PAN_W-1:0];
            ADDR_STEP: step_q   <= wr_data[GAIN_W-1:0];
            default: ;
         endcase
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_ramp
      vol_ramp u_ramp (
         .clk          (clk),
         .rst          (rst),
         .tick         (sample_tick),
         .step         (step_q),
         .tgt          (tgt_q[i]),
         .override_en  ((i == 3) && fade_out),
         .override_tgt ('0),
         .cur          (cur[i]),
         .at_tgt       (at_tgt[i])
      );
   end

   always_comb begin
      state_next = state;
      pan_load   = 1'b0;
      done_set   = 1'b0;
      case (state)
         IDLE:     if (accept && (wr_addr == ADDR_PAN)) state_next = FADE_OUT;
         FADE_OUT: if (at_tgt[3]) state_next = SWAP;
         SWAP: begin
            pan_load   = 1'b1;
            state_next = FADE_IN;
         end
         FADE_IN: begin
            if (at_tgt[3]) begin
               state_next = IDLE;
               done_set   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pan      <= '0;
         pan_done <= 1'b0;
      end else begin
         state    <= state_next;
         pan_done <= done_set;
         if (pan_load) pan <= shadow_q;
      end
   end

   assign busy          = (state != IDLE) || !(&at_tgt);
   assign volume1       = {{(VOL_W-GAIN_W){1'b0}}, cur[0]};
   assign volume2       = {{(VOL_W-GAIN_W){1'b0}}, cur[1]};
   assign volume3       = {{(VOL_W-GAIN_W){1'b0}}, cur[2]};
   assign volume_master = {{(VOL_W-GAIN_W){1'b0}}, cur[3]};

endmodule
